// File: rtl/tap_result_pkg.sv
// Shared types and constants for the tap result collector.
// Optional macro: TAP_RESULT_TIMESTAMP_EN adds a 32-bit capture timestamp.
package tap_result_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         TS_W      = 32;

`ifdef TAP_RESULT_TIMESTAMP_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BODY,
    S_TS,
    S_TRL
  } ser_state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY,
    S_TRL
  } ser_state_e;
`endif

  // Bytes on the wire per result, header and trailer included.
  function automatic int frame_len(input int num_of_taps);
`ifdef TAP_RESULT_TIMESTAMP_EN
    return num_of_taps + 2 + TS_W / 8;
`else
    return num_of_taps + 2;
`endif
  endfunction

endpackage

// File: rtl/tap_result_fifo.sv
// Synchronous FIFO, pointers carry a wrap bit for full/empty.
// Ports: clk, res (async low), wr_en/din, rd_en/dout, full, empty.
module tap_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_wr;
  logic             do_rd;

  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/tap_result_collector.sv
// Captures NLFSR tap search results, restarts the search, frames results.
// Ports: clk, res, found, co_buf -> search_res, tx_*, fifo_full, counters.
// Optional macro: TAP_RESULT_TIMESTAMP_EN (timestamp bytes after body).
module tap_result_collector
  import tap_result_pkg::*;
#(
  parameter int NUM_OF_TAPS = 16,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     found,
  input  logic [NUM_OF_TAPS*8-1:0] co_buf,
  output logic                     search_res,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     fifo_full,
  output logic [CNT_W-1:0]         found_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int BODY_W = NUM_OF_TAPS * 8;
`ifdef TAP_RESULT_TIMESTAMP_EN
  localparam int ENT_W  = BODY_W + TS_W;
`else
  localparam int ENT_W  = BODY_W;
`endif
  localparam int IDX_W  =
    (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_OF_TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ser_state_e        state;
  logic              found_q;
  logic              cap;
  logic              wr_en;
  logic              rd_en;
  logic              full;
  logic              empty;
  logic [ENT_W-1:0]  din;
  logic [ENT_W-1:0]  dout;
  logic [BODY_W-1:0] sh;
  logic [BODY_W-1:0] sh_nx;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        cs;
  logic [7:0]        cs_nx;

  assign cap   = found && !found_q;
  assign wr_en = cap && !full;
  assign rd_en = (state == S_IDLE) && !empty;
  assign sh_nx = sh >> 8;
  assign cs_nx = cs ^ tx_data;

  assign fifo_full = full;

`ifdef TAP_RESULT_TIMESTAMP_EN
  logic [TS_W-1:0] cyc;
  logic [TS_W-1:0] tsh;
  logic [TS_W-1:0] tsh_nx;
  logic [1:0]      tidx;

  assign tsh_nx = tsh >> 8;
  assign din    = {cyc, co_buf};

  always_ff @(posedge clk or negedge res) begin
    if (!res) cyc <= '0;
    else      cyc <= cyc + 1'b1;
  end
`else
  assign din = co_buf;
`endif

  tap_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .wr_en (wr_en),
    .din   (din),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  // Rising-edge capture; drops are still acknowledged with a restart.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      found_q    <= 1'b0;
      search_res <= 1'b0;
      found_cnt  <= '0;
      drop_cnt   <= '0;
    end else begin
      found_q    <= found;
      search_res <= cap;
      if (cap && !full && found_cnt != CNT_MAX)
        found_cnt <= found_cnt + 1'b1;
      if (cap && full && drop_cnt != CNT_MAX)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Each state presents its byte one edge ahead; sh shifts per
  // accepted body byte so the next byte is always sh_nx[7:0].
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= S_IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      sh       <= '0;
      idx      <= '0;
      cs       <= '0;
`ifdef TAP_RESULT_TIMESTAMP_EN
      tsh      <= '0;
      tidx     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            sh       <= dout[BODY_W-1:0];
`ifdef TAP_RESULT_TIMESTAMP_EN
            tsh      <= dout[ENT_W-1 -: TS_W];
`endif
            cs       <= '0;
            tx_data  <= FRAME_HDR;
            tx_valid <= 1'b1;
            state    <= S_HDR;
          end
        end
        S_HDR: begin
          if (tx_ready) begin
            idx     <= '0;
            tx_data <= sh[7:0];
            state   <= S_BODY;
          end
        end
        S_BODY: begin
          if (tx_ready) begin
            cs <= cs_nx;
            sh <= sh_nx;
            if (idx == IDX_LAST) begin
`ifdef TAP_RESULT_TIMESTAMP_EN
              tidx    <= '0;
              tx_data <= tsh[7:0];
              state   <= S_TS;
`else
              tx_data <= cs_nx;
              state   <= S_TRL;
`endif
            end else begin
              idx     <= idx + 1'b1;
              tx_data <= sh_nx[7:0];
            end
          end
        end
`ifdef TAP_RESULT_TIMESTAMP_EN
        S_TS: begin
          if (tx_ready) begin
            cs  <= cs_nx;
            tsh <= tsh_nx;
            if (tidx == 2'd3) begin
              tx_data <= cs_nx;
              state   <= S_TRL;
            end else begin
              tidx    <= tidx + 1'b1;
              tx_data <= tsh_nx[7:0];
            end
          end
        end
`endif
        S_TRL: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tap_result_collector.md
Name: tap_result_collector

Overview:
- Sits directly downstream of the NLFSR tap search stage.
- On each rising edge of `found`, captures the winning tap vector `co_buf` and queues it in a small FIFO.
- Pulses a restart back to the search stage's `ext_res` so the search resumes.
- Serializes queued results as framed bytes over a valid/ready byte stream toward the host link.

Parameters:
- NUM_OF_TAPS, 16, number of 8-bit tap indices per result; frame body length in bytes.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the found and drop counters.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous, active-low reset.
- found  in  1  search stage success flag; level, may be held for many cycles.
- co_buf  in  NUM_OF_TAPS*8  tap vector; tap k is in bits [8k+7:8k]; valid in the cycle `found` rises.
- search_res  out  1  one-cycle restart pulse to the search stage's `ext_res`.
- tx_data  out  8  stream byte.
- tx_valid  out  1  `tx_data` is valid.
- tx_ready  in  1  sink accepts the byte when `tx_valid && tx_ready` at a clock edge.
- fifo_full  out  1  FIFO holds DEPTH entries.
- found_cnt  out  CNT_W  results accepted into the FIFO; saturating.
- drop_cnt  out  CNT_W  results discarded because the FIFO was full; saturating.

Behaviour:
- Reset (res=0, asynchronous): all outputs are 0, the FIFO is empty, the FSM is in IDLE, and found_q is 0.
- Capture:
  - A capture event occurs when `found && !found_q` (found_q is `found` registered).
  - On a capture event with the FIFO not full at the start of the cycle: write `co_buf` and increment `found_cnt`.
  - On a capture event with the FIFO full: no write; increment `drop_cnt`.
  - There is no bypass: a pop in the same cycle does not free a slot for that cycle's write.
  - Both counters hold at all-ones once reached.
- search_res is high for exactly the one cycle after every capture event, whether the result was accepted or dropped.
- FIFO:
  - Read and write pointers are log2(DEPTH) bits plus a wrap bit.
  - Full when pointer indices are equal and wrap bits differ; empty when pointers are fully equal.
  - Pointers wrap modulo DEPTH.
  - fifo_full is registered, so it reflects the state after the current edge.
- Serializer FSM, states IDLE, HDR, BODY, TRL:
  - IDLE: tx_valid=0. If the FIFO is not empty, pop the head into shift register `sh`, clear checksum `cs`, and go to HDR.
  - HDR: tx_data=0xA5, tx_valid=1. On acceptance, set idx=0 and go to BODY.
  - BODY: tx_data = byte idx of `sh`, low byte first. On acceptance, `cs ^= byte` and idx++. When idx=NUM_OF_TAPS-1 is accepted, go to TRL.
  - TRL: tx_data=cs, the XOR of all body bytes. On acceptance, go to IDLE.
- Handshake: `tx_data` and `tx_valid` are registered and held stable while `tx_valid && !tx_ready`. tx_valid never drops before acceptance.
- Throughput: minimum IDLE-to-IDLE is NUM_OF_TAPS+3 cycles with tx_ready=1. Capture-to-first-byte (0xA5 valid) latency is 3 cycles.
- Reset mid-frame aborts the frame; the partial frame is not resumed.

Optional Feature:
- Macro: TAP_RESULT_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter (reset 0, wraps) is stored alongside each FIFO entry at capture.
  - Frame order is HDR, body, 4 timestamp bytes (LSB first), TRL.
  - The timestamp bytes are included in cs; an extra FSM state TS is added.
- Undefined: no counter and no TS state; the frame is exactly NUM_OF_TAPS+2 bytes.

Decomposition:
- Package `tap_result_pkg`:
  - FRAME_HDR = 8'hA5.
  - Serializer state enum.
  - Function frame_len(NUM_OF_TAPS) that accounts for the macro.
- Sub-module `tap_result_fifo`: synchronous FIFO with parameters WIDTH and DEPTH and ports wr_en/din/rd_en/dout/full/empty, same clk/res.

Test Plan (NUM_OF_TAPS=2, DEPTH=2, macro undefined unless noted):
1. Reset release, idle inputs -> tx_valid=0, search_res=0, fifo_full=0, counters 0 for 20 cycles.
2. found rises with co_buf=16'h3C81, tx_ready=1 -> search_res high exactly 1 cycle; stream A5,81,3C,BD; found_cnt=1.
3. found held high 10 cycles, then low, then high again -> two captures total, two frames, found_cnt=2.
4. tx_ready=0 for 5 cycles while a BODY byte is valid -> tx_data is unchanged throughout; stream A5,81,3C,BD remains intact.
5. tx_ready=0; four found pulses with co_buf=1,2,3,4 -> entry 1 is in the shifter and entries 2,3 are in the FIFO; fifo_full=1; drop_cnt=1; four search_res pulses. After tx_ready=1, frames for 1,2,3 arrive in order.
6. Assert res during BODY -> tx_valid=0 immediately; FIFO empty; after release no stale frame. With TAP_RESULT_TIMESTAMP_EN, a capture at cycle 0x10 yields the frame A5,81,3C,10,00,00,00,AD.
